p_emap_gather: RTL and testbench

- Parametrised successor of the 8-lane P-vector element mapper. Gathers NUM_OUT scalar elements per beat from a banked vector memory, using a list of column indices supplied by the sparse-matrix index stream.
- Each index is split into a memory row (index / NUM_UNITS) and a lane (index % NUM_UNITS). The block walks up to MAX_CHUNKS chunks of the list, then emits one gathered row per chunk over a valid/ready handshake.
- Sits between the index-matrix reader and the multiply/accumulate array.

---
 rtl/p_emap_gather.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_p_emap_gather.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_emap_gather.sv
// p_emap_gather: gathers NUM_OUT elements per beat from a banked vector memory
// using chunked column-index lists, emitting one gathered row per chunk over a
// valid/ready handshake through a three-stage pipeline.
module p_emap_gather #(
    parameter int unsigned      NUM_OUT    = 8,
    parameter int unsigned      ELEM_W     = 32,
    parameter int unsigned      NUM_UNITS  = 8,
    parameter int unsigned      MEM_DEPTH  = 1024,
    parameter int unsigned      ADDR_W     = $clog2(MEM_DEPTH),
    parameter int unsigned      IDX_W      = 32,
    parameter int unsigned      MAX_CHUNKS = 4,
    parameter logic [IDX_W-1:0] INVALID    = {IDX_W{1'b1}}
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [NUM_UNITS*ELEM_W-1:0]         wr_data,
    input  logic                                start,
    input  logic [MAX_CHUNKS*NUM_OUT*IDX_W-1:0] col_nos,
    input  logic [IDX_W-1:0]                    no_of_multiples,
    output logic                                busy,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_OUT*ELEM_W-1:0]           output_row,
    output logic                                out_last,
    output logic                                done,
    output logic                                wr_drop,
    output logic                                oor_err
);

    localparam int unsigned WORD_W = NUM_UNITS * ELEM_W;
    localparam int unsigned LIST_W = MAX_CHUNKS * NUM_OUT * IDX_W;
    localparam int unsigned SH     = $clog2(NUM_UNITS);
    localparam int unsigned LW     = (SH > 0) ? SH : 1;
    localparam int unsigned CW     = $clog2(MAX_CHUNKS + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    // Control state
    state_e              state_q, state_d;
    logic [CW-1:0]       chunk_q, chunk_d;
    logic [CW-1:0]       count_q, count_d;
    logic [LIST_W-1:0]   cols_q, cols_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_drop_q, wr_drop_d;
    logic                oor_q, oor_d;

    // Stage 1: decoded row/lane per output lane
    logic                s1_valid_q, s1_valid_d;
    logic                s1_last_q, s1_last_d;
    logic [ADDR_W-1:0]   s1_row_q [NUM_OUT];
    logic [ADDR_W-1:0]   s1_row_d [NUM_OUT];
    logic [LW-1:0]       s1_lane_q [NUM_OUT];
    logic [LW-1:0]       s1_lane_d [NUM_OUT];
    logic                s1_zero_q [NUM_OUT];
    logic                s1_zero_d [NUM_OUT];

    // Stage 2: memory words read for each lane
    logic                s2_valid_q, s2_valid_d;
    logic                s2_last_q, s2_last_d;
    logic [WORD_W-1:0]   s2_word_q [NUM_OUT];
    logic [WORD_W-1:0]   s2_word_d [NUM_OUT];
    logic [LW-1:0]       s2_lane_q [NUM_OUT];
    logic [LW-1:0]       s2_lane_d [NUM_OUT];
    logic                s2_zero_q [NUM_OUT];
    logic                s2_zero_d [NUM_OUT];

    // Stage 3: output register
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [ELEM_W-1:0]   out_lane_q [NUM_OUT];
    logic [ELEM_W-1:0]   out_lane_d [NUM_OUT];

    logic [WORD_W-1:0]   mem_q [MEM_DEPTH];

    // Issue-side signals from the FSM
    logic                issue;
    logic                issue_last;
    logic [CW-1:0]       issue_k;
    logic [LIST_W-1:0]   issue_list;
    logic [CW-1:0]       count_in;

    // Per-lane index decode
    logic [IDX_W-1:0]    idx_w [NUM_OUT];
    logic [IDX_W-1:0]    row_full_w [NUM_OUT];
    logic                inv_w [NUM_OUT];
    logic                oor_w [NUM_OUT];
    logic                any_oor;

    logic advance;
    logic accept;
    logic last_accept;

    // The whole pipeline moves together whenever the output slot can take a beat.
    assign advance     = !out_valid_q || out_ready;
    assign accept      = (state_q == StIdle) && start && !busy_q;
    assign last_accept = (state_q == StDrain) && out_valid_q && out_ready && out_last_q;

    // Clamp the requested chunk count to what the list can hold.
    always_comb begin
        count_in = CW'(no_of_multiples);
        if (no_of_multiples > IDX_W'(MAX_CHUNKS)) begin
            count_in = CW'(MAX_CHUNKS);
        end
    end

    // FSM next-state; chunk 0 issues straight from col_nos on the accept cycle.
    always_comb begin
        state_d    = state_q;
        chunk_d    = chunk_q;
        count_d    = count_q;
        cols_d     = cols_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_k    = '0;
        issue_list = cols_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cols_d  = col_nos;
                    count_d = count_in;
                    if (count_in != '0) begin
                        issue      = 1'b1;
                        issue_list = col_nos;
                        issue_last = (count_in == CW'(1));
                        if (count_in == CW'(1)) begin
                            state_d = StDrain;
                        end else begin
                            state_d = StIssue;
                            chunk_d = CW'(1);
                        end
                    end
                end
            end
            StIssue: begin
                if (advance) begin
                    issue      = 1'b1;
                    issue_k    = chunk_q;
                    issue_last = (chunk_q == (count_q - CW'(1)));
                    if (issue_last) begin
                        state_d = StDrain;
                    end else begin
                        chunk_d = chunk_q + CW'(1);
                    end
                end
            end
            StDrain: begin
                if (last_accept) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status flags: busy covers the done cycle so a start there is ignored.
    always_comb begin
        busy_d    = (state_d != StIdle) || last_accept;
        done_d    = last_accept || (accept && (count_in == '0));
        wr_drop_d = wr_en && busy_q;
        oor_d     = (accept ? 1'b0 : oor_q) | any_oor;
    end

    // Split each lane's index into row/lane; chunk k takes the k-th slot group from the top.
    always_comb begin
        int unsigned slot;
        slot    = 0;
        any_oor = 1'b0;
        for (int j = 0; j < NUM_OUT; j++) begin
            slot          = NUM_OUT * (MAX_CHUNKS - 1 - 32'(issue_k)) + j;
            idx_w[j]      = IDX_W'(issue_list >> (slot * IDX_W));
            row_full_w[j] = idx_w[j] >> SH;
            inv_w[j]      = (idx_w[j] == INVALID);
            oor_w[j]      = !inv_w[j] && (row_full_w[j] >= IDX_W'(MEM_DEPTH));
            any_oor       = any_oor | (issue && oor_w[j]);
        end
    end

    // Pipeline next-state; every stage holds while the output beat is stalled.
    always_comb begin
        int unsigned sh_amt;
        sh_amt      = 0;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        for (int j = 0; j < NUM_OUT; j++) begin
            s1_row_d[j]   = s1_row_q[j];
            s1_lane_d[j]  = s1_lane_q[j];
            s1_zero_d[j]  = s1_zero_q[j];
            s2_word_d[j]  = s2_word_q[j];
            s2_lane_d[j]  = s2_lane_q[j];
            s2_zero_d[j]  = s2_zero_q[j];
            out_lane_d[j] = out_lane_q[j];
        end
        if (advance) begin
            s1_valid_d  = issue;
            s1_last_d   = issue_last;
            s2_valid_d  = s1_valid_q;
            s2_last_d   = s1_last_q;
            out_valid_d = s2_valid_q;
            out_last_d  = s2_last_q;
            for (int j = 0; j < NUM_OUT; j++) begin
                s1_row_d[j]  = row_full_w[j][ADDR_W-1:0];
                s1_lane_d[j] = LW'(idx_w[j] & IDX_W'(NUM_UNITS - 1));
                s1_zero_d[j] = inv_w[j] || oor_w[j];
                s2_word_d[j] = mem_q[s1_row_q[j]];
                s2_lane_d[j] = s1_lane_q[j];
                s2_zero_d[j] = s1_zero_q[j];
                // Element 0 sits in the most significant slot of the word.
                sh_amt = (NUM_UNITS - 1 - 32'(s2_lane_q[j])) * ELEM_W;
                if (s2_valid_q) begin
                    out_lane_d[j] = s2_zero_q[j] ? '0 : ELEM_W'(s2_word_q[j] >> sh_amt);
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            chunk_q     <= '0;
            count_q     <= '0;
            cols_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_drop_q   <= 1'b0;
            oor_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int j = 0; j < NUM_OUT; j++) begin
                s1_row_q[j]   <= '0;
                s1_lane_q[j]  <= '0;
                s1_zero_q[j]  <= 1'b0;
                s2_word_q[j]  <= '0;
                s2_lane_q[j]  <= '0;
                s2_zero_q[j]  <= 1'b0;
                out_lane_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            chunk_q     <= chunk_d;
            count_q     <= count_d;
            cols_q      <= cols_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_drop_q   <= wr_drop_d;
            oor_q       <= oor_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            for (int j = 0; j < NUM_OUT; j++) begin
                s1_row_q[j]   <= s1_row_d[j];
                s1_lane_q[j]  <= s1_lane_d[j];
                s1_zero_q[j]  <= s1_zero_d[j];
                s2_word_q[j]  <= s2_word_d[j];
                s2_lane_q[j]  <= s2_lane_d[j];
                s2_zero_q[j]  <= s2_zero_d[j];
                out_lane_q[j] <= out_lane_d[j];
            end
        end
    end

    // Vector memory; not reset, writes only land while idle.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign output_row[g*ELEM_W +: ELEM_W] = out_lane_q[g];
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign wr_drop   = wr_drop_q;
    assign oor_err   = oor_q;

endmodule

// File: tb/tb_p_emap_gather.sv
// Bench for p_emap_gather: table of gather scenarios checked against a
// scoreboard of expected beats, plus reset-during-gather sequence.
module tb_p_emap_gather;

    localparam int NO    = 8;
    localparam int EW    = 32;
    localparam int NU    = 8;
    localparam int MD    = 1024;
    localparam int AW    = 10;
    localparam int IW    = 32;
    localparam int MC    = 4;
    localparam int NSLOT = MC * NO;
    localparam int NROWS = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [NU*EW-1:0]    wr_data;
    logic                start;
    logic [NSLOT*IW-1:0] col_nos;
    logic [IW-1:0]       no_of_multiples;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [NO*EW-1:0]    output_row;
    logic                out_last;
    logic                done;
    logic                wr_drop;
    logic                oor_err;

    always #5 clk = ~clk;

    p_emap_gather dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .start           (start),
        .col_nos         (col_nos),
        .no_of_multiples (no_of_multiples),
        .busy            (busy),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .output_row      (output_row),
        .out_last        (out_last),
        .done            (done),
        .wr_drop         (wr_drop),
        .oor_err         (oor_err)
    );

    typedef struct packed {
        logic [NO*EW-1:0] row;
        logic             last;
    } beat_t;

    typedef struct {
        int kind;
        int count;
        int ready_mode;
        int exp_beats;
        int exp_busy;   // -1: not checked
        int exp_oor;
        int wr_mid;
        int wr_start;
    } vec_t;

    beat_t         exp_q[$];
    vec_t          vecs[8];
    logic [EW-1:0] elem_m [NROWS][NU];
    logic [IW-1:0] cols_m [NSLOT];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk_row(input string name, input logic [NO*EW-1:0] act,
                           input logic [NO*EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NU*EW-1:0] pack_word(input int row);
        logic [NU*EW-1:0] w;
        w = '0;
        for (int r = 0; r < NU; r++) w[(NU-r)*EW-1 -: EW] = elem_m[row][r];
        return w;
    endfunction

    function automatic logic [EW-1:0] exp_elem(input logic [IW-1:0] idx);
        if (idx == {IW{1'b1}}) return '0;
        if ((idx / NU) >= MD) return '0;
        return elem_m[idx / NU][idx % NU];
    endfunction

    function automatic logic [NO*EW-1:0] exp_row(input int k);
        logic [NO*EW-1:0] v;
        v = '0;
        for (int j = 0; j < NO; j++) v[j*EW +: EW] = exp_elem(cols_m[MC*NO - NO*(k+1) + j]);
        return v;
    endfunction

    task automatic fill_cols(input int kind);
        int lane_list[NO];
        lane_list = '{15, 6, 13, 4, 11, 2, 9, 0};
        for (int s = 0; s < NSLOT; s++) begin
            case (kind)
                0:       cols_m[s] = '1;
                3: begin
                    if (s % 7 == 0)       cols_m[s] = '1;
                    else if (s % 11 == 0) cols_m[s] = 8 * MD + s;
                    else                  cols_m[s] = (s * 3) % 128;
                end
                default: cols_m[s] = (s * 5 + 3) % 128;
            endcase
        end
        if (kind == 0) begin
            for (int j = 0; j < NO; j++) cols_m[NSLOT - NO + j] = lane_list[j];
        end
        if (kind == 2) begin
            cols_m[NSLOT - NO + 0] = '1;
            cols_m[NSLOT - NO + 3] = '1;
            cols_m[NSLOT - NO + 5] = 8 * MD;
        end
        for (int s = 0; s < NSLOT; s++) col_nos[s*IW +: IW] = cols_m[s];
    endtask

    task automatic run_vec(input vec_t v);
        beat_t b;
        int nb, busy_cnt, done_n, first_valid, last_n, beats;
        @(negedge clk);
        fill_cols(v.kind);
        if (v.wr_start != 0) begin
            for (int r = 0; r < NU; r++) elem_m[0][r] = 32'hB000_0000 + r;
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = pack_word(0);
        end
        start           = 1'b1;
        no_of_multiples = v.count;
        out_ready       = 1'b1;
        nb = (v.count > MC) ? MC : v.count;
        for (int k = 0; k < nb; k++) begin
            b.row  = exp_row(k);
            b.last = (k == nb - 1);
            exp_q.push_back(b);
        end
        busy_cnt = 0; done_n = -1; first_valid = -1; last_n = -1; beats = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (v.wr_mid != 0 && n == 1) begin
                // Write and a second start while busy: both must be ignored.
                wr_en   = 1'b1;
                wr_addr = AW'(2);
                wr_data = ~pack_word(2);
                start   = 1'b1;
                no_of_multiples = 1;
            end
            out_ready = (v.ready_mode == 0) ? 1'b1 : (n % 3 == 0);
            busy_cnt += int'(busy);
            if (out_valid) begin
                if (first_valid < 0) first_valid = n;
                if (exp_q.size() == 0) begin
                    chk_int("extra_beat", 1, 0);
                end else begin
                    chk_row("beat_row", output_row, exp_q[0].row);
                    chk_int("beat_last", int'(out_last), int'(exp_q[0].last));
                    if (out_ready) begin
                        if (exp_q[0].last) last_n = n;
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
            if (v.wr_mid != 0 && n == 2) chk_int("wr_drop", int'(wr_drop), 1);
            if (done) begin
                if (done_n >= 0) chk_int("done_twice", 1, 0);
                else done_n = n;
            end
            if (done_n >= 0 && n == done_n + 1) begin
                chk_int("busy_after_done", int'(busy), 0);
                break;
            end
        end
        if (done_n < 0) chk_int("done_timeout", 0, 1);
        chk_int("beat_count", beats, v.exp_beats);
        if (v.exp_busy >= 0) chk_int("busy_cycles", busy_cnt, v.exp_busy);
        chk_int("oor_err", int'(oor_err), v.exp_oor);
        if (v.ready_mode == 0 && v.exp_beats > 0) chk_int("latency", first_valid, 3);
        if (v.count == 0) chk_int("done_time", done_n, 1);
        else              chk_int("done_time", done_n, last_n + 1);
        exp_q.delete();
    endtask

    task automatic rst_mid();
        int bad;
        @(negedge clk);
        fill_cols(1);
        start           = 1'b1;
        no_of_multiples = 4;
        out_ready       = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk_int("rst_pre_valid", int'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_int("rst_valid", int'(out_valid), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_last", int'(out_last), 0);
        chk_int("rst_done", int'(done), 0);
        chk_row("rst_row", output_row, '0);
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || out_valid || busy) bad++;
        end
        chk_int("rst_quiet", bad, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        col_nos = '0; no_of_multiples = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_valid", int'(out_valid), 0);
        chk_int("reset_last", int'(out_last), 0);
        chk_int("reset_done", int'(done), 0);
        chk_int("reset_wr_drop", int'(wr_drop), 0);
        chk_int("reset_oor", int'(oor_err), 0);
        chk_row("reset_row", output_row, '0);
        rst = 1'b0;

        // Element e (row e/8, lane e%8) holds 0x100+e so that element 0 is non-zero.
        for (int row = 0; row < NROWS; row++) begin
            for (int r = 0; r < NU; r++) elem_m[row][r] = 32'h100 + row * NU + r;
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(row);
            wr_data = pack_word(row);
        end
        @(negedge clk);
        wr_en = 1'b0;

        //          kind cnt rdy beats busy oor wmid wstart
        vecs[0] = '{0,   1,  0,  1,    4,   0,  0,   0};
        vecs[1] = '{1,   4,  0,  4,    7,   0,  1,   0};
        vecs[2] = '{1,   4,  1,  4,    -1,  0,  0,   0};
        vecs[3] = '{2,   1,  0,  1,    4,   1,  0,   0};
        vecs[4] = '{1,   0,  0,  0,    0,   0,  0,   0};
        vecs[5] = '{1,   9,  0,  4,    7,   0,  0,   0};
        vecs[6] = '{3,   4,  0,  4,    7,   1,  0,   1};
        vecs[7] = '{0,   2,  1,  2,    -1,  0,  0,   0};
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        rst_mid();
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
